// File: rtl/bp_fe_queue_ckpt.sv
// Checkpointing FE->BE instruction queue with speculative read, commit, rollback and clear.
// Optional same-cycle bypass into an empty queue: define BP_FE_QUEUE_BYPASS_EN.
module bp_fe_queue_ckpt #(
  parameter  int width_p      = 128,
  parameter  int els_p        = 8,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [width_p-1:0]      fe_queue_i,
  input  logic                    fe_queue_v_i,
  output logic                    fe_queue_ready_o,
  output logic [width_p-1:0]      fe_queue_o,
  output logic                    fe_queue_v_o,
  input  logic                    fe_queue_yumi_i,
  input  logic                    fe_queue_deq_i,
  input  logic                    fe_queue_roll_i,
  input  logic                    fe_queue_clr_i,
  output logic [ptr_width_lp-1:0] count_o
);

  localparam int idx_width_lp = ptr_width_lp - 1;

  logic [ptr_width_lp-1:0] wptr_q, rptr_q, cptr_q;
  logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
  logic [width_p-1:0]      mem_q [els_p];
  logic [width_p-1:0]      mem_rd;
  logic                    full, enq;

  // Same index with opposite wrap bits means wptr has lapped cptr.
  assign full = (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0])
              & (wptr_q[idx_width_lp] != cptr_q[idx_width_lp]);
  assign fe_queue_ready_o = ~full;
  assign enq              = fe_queue_v_i & fe_queue_ready_o;
  assign count_o          = wptr_q - cptr_q;
  assign mem_rd           = mem_q[rptr_q[idx_width_lp-1:0]];

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
    wptr_n = wptr_q + ptr_width_lp'(enq);
    cptr_n = cptr_q + ptr_width_lp'(fe_queue_deq_i);
    rptr_n = rptr_q;
    if (fe_queue_clr_i) begin
      rptr_n = wptr_n;
      cptr_n = wptr_n;
    end else if (fe_queue_roll_i) begin
      rptr_n = cptr_n;
    end else if (fe_queue_yumi_i) begin
      rptr_n = rptr_q + ptr_width_lp'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all pointers update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_n;
      rptr_q <= rptr_n;
      cptr_q <= cptr_n;
    end
  end

  // NOTE: the packet array has no reset; pointers alone define which slots hold live data.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q[idx_width_lp-1:0]] <= fe_queue_i;
  end

`ifdef BP_FE_QUEUE_BYPASS_EN
  logic bypass;
  // Nothing unread: present the incoming packet directly; it is still written for reissue.
  assign bypass       = (rptr_q == wptr_q) & ~fe_queue_roll_i & ~fe_queue_clr_i;
  assign fe_queue_o   = bypass ? fe_queue_i : mem_rd;
  assign fe_queue_v_o = bypass ? enq : (rptr_q != wptr_q);
`else
  assign fe_queue_o   = mem_rd;
  assign fe_queue_v_o = (rptr_q != wptr_q);
`endif

  yumi_needs_valid_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_yumi_i |-> fe_queue_v_o);
  deq_needs_issued_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fe_queue_deq_i |-> (cptr_q != rptr_q));
  roll_clr_exclusive_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(fe_queue_roll_i && fe_queue_clr_i));

endmodule

// File: tb/tb_bp_fe_queue_ckpt.sv
// Randomized self-checking bench for bp_fe_queue_ckpt against a queue-of-packets reference model.
module tb_bp_fe_queue_ckpt;

  localparam int width_p      = 128;
  localparam int els_p        = 8;
  localparam int ptr_width_lp = $clog2(els_p) + 1;

  logic                    clk_i = 1'b0;
  logic                    reset_n_i = 1'b0;
  logic [width_p-1:0]      fe_queue_i = '0;
  logic                    fe_queue_v_i = 1'b0;
  logic                    fe_queue_ready_o;
  logic [width_p-1:0]      fe_queue_o;
  logic                    fe_queue_v_o;
  logic                    fe_queue_yumi_i = 1'b0;
  logic                    fe_queue_deq_i = 1'b0;
  logic                    fe_queue_roll_i = 1'b0;
  logic                    fe_queue_clr_i = 1'b0;
  logic [ptr_width_lp-1:0] count_o;

  bp_fe_queue_ckpt #(.width_p(width_p), .els_p(els_p)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
    .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o), .fe_queue_yumi_i(fe_queue_yumi_i),
    .fe_queue_deq_i(fe_queue_deq_i), .fe_queue_roll_i(fe_queue_roll_i),
    .fe_queue_clr_i(fe_queue_clr_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic                    v;
    logic [width_p-1:0]      data;
    logic                    ready;
    logic [ptr_width_lp-1:0] count;
  } obs_t;

  // Reference model: q holds every uncommitted packet oldest first; n_iss of them have been issued.
  logic [width_p-1:0] q[$];
  int   n_iss = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  obs_t exp_o, act_o;

  function automatic obs_t model_out();
    obs_t o;
    o.ready = (q.size() < els_p);
    o.count = ptr_width_lp'(q.size());
    o.v     = (n_iss < q.size());
    o.data  = o.v ? q[n_iss] : '0;
`ifdef BP_FE_QUEUE_BYPASS_EN
    if (n_iss == q.size() && !fe_queue_roll_i && !fe_queue_clr_i) begin
      o.v    = fe_queue_v_i && o.ready;
      o.data = o.v ? fe_queue_i : '0;
    end
`endif
    return o;
  endfunction

  function automatic obs_t dut_out();
    obs_t o;
    o.v     = fe_queue_v_o;
    o.data  = fe_queue_v_o ? fe_queue_o : '0;
    o.ready = fe_queue_ready_o;
    o.count = count_o;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("v=%0b data=%h ready=%0b count=%0d", o.v, o.data, o.ready, o.count);
  endfunction

  function automatic void model_update();
    bit enq;
    if (!reset_n_i) begin
      q.delete();
      n_iss = 0;
      return;
    end
    enq = fe_queue_v_i && (q.size() < els_p);
    if (fe_queue_deq_i && q.size() > 0) begin
      void'(q.pop_front());
      n_iss--;
    end
    if (enq) q.push_back(fe_queue_i);
    if (fe_queue_clr_i) begin
      q.delete();
      n_iss = 0;
    end else if (fe_queue_roll_i) n_iss = 0;
    else if (fe_queue_yumi_i) n_iss++;
  endfunction

  function automatic logic [width_p-1:0] rand_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic v, input logic [width_p-1:0] pkt, input logic yumi,
                       input logic deq, input logic roll, input logic clr);
    fe_queue_v_i    = v;
    fe_queue_i      = pkt;
    fe_queue_yumi_i = yumi;
    fe_queue_deq_i  = deq;
    fe_queue_roll_i = roll;
    fe_queue_clr_i  = clr;
  endtask

  task automatic advance();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0, 0, 0);
    reset_n_i = 1'b0;
    advance();
    advance();
    @(negedge clk_i);
    act_o = dut_out();
    n_cmp++;
    if (act_o !== obs_t'{1'b0, '0, 1'b1, '0}) begin
      n_err++;
      $display("FAIL reset: got %s, expected v=0 ready=1 count=0", fmt(act_o));
    end
    #1 reset_n_i = 1'b1;
    advance();
  endtask

  task automatic test_bypass();
    drive(1, width_p'('hA5), 0, 0, 0, 0);
    #1;
    act_o = dut_out();
    n_cmp++;
`ifdef BP_FE_QUEUE_BYPASS_EN
    if (act_o.v !== 1'b1 || act_o.data !== width_p'('hA5)) begin
`else
    if (act_o.v !== 1'b0) begin
`endif
      n_err++;
      $display("FAIL bypass_same_cycle: got %s", fmt(act_o));
    end
    advance();
    drive(0, '0, 0, 0, 0, 1);
    @(negedge clk_i);
    exp_o = model_out(); act_o = dut_out(); n_cmp++;
    if (act_o !== exp_o) begin
      n_err++;
      $display("FAIL bypass_next: got %s, expected %s", fmt(act_o), fmt(exp_o));
    end
    advance();
  endtask

  task automatic test_fill();
    for (int i = 0; i <= els_p; i++) begin
      if (i < els_p) drive(1, rand_pkt(), 0, 0, 0, 0);
      else drive(1, rand_pkt(), 0, 0, 0, 0);  // one more attempt while full is refused
      @(negedge clk_i);
      exp_o = model_out(); act_o = dut_out(); n_cmp++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL fill[%0d]: got %s, expected %s", i, fmt(act_o), fmt(exp_o));
      end
      advance();
    end
  endtask

  task automatic test_roll();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0, 1, 2: drive(0, '0, 1, 0, 0, 0);
        3:       drive(0, '0, 0, 0, 1, 0);
        default: drive(0, '0, 0, 0, 0, 0);
      endcase
      @(negedge clk_i);
      exp_o = model_out(); act_o = dut_out(); n_cmp++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL roll[%0d]: got %s, expected %s", i, fmt(act_o), fmt(exp_o));
      end
      advance();
    end
  endtask

  task automatic test_deq_roll();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0, 1:    drive(0, '0, 1, 0, 0, 0);
        2:       drive(1, rand_pkt(), 0, 1, 0, 0);  // still full this cycle: must be refused
        3:       drive(0, '0, 0, 1, 0, 0);
        4:       drive(0, '0, 0, 0, 1, 0);
        default: drive(0, '0, 0, 0, 0, 0);
      endcase
      @(negedge clk_i);
      exp_o = model_out(); act_o = dut_out(); n_cmp++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL deq_roll[%0d]: got %s, expected %s", i, fmt(act_o), fmt(exp_o));
      end
      advance();
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, rand_pkt(), 0, 0, 0, 1);
      else drive(0, '0, 0, 0, 0, 0);
      @(negedge clk_i);
      exp_o = model_out(); act_o = dut_out(); n_cmp++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL clr[%0d]: got %s, expected %s", i, fmt(act_o), fmt(exp_o));
      end
      advance();
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    for (int i = 0; i < 24; i++) begin
      drive(sent < 20, rand_pkt(), 0, n_iss > 0, 0, 0);
      fe_queue_yumi_i = model_out().v;
      if (fe_queue_v_i) sent++;
      @(negedge clk_i);
      exp_o = model_out(); act_o = dut_out(); n_cmp++;
      if (act_o !== exp_o || !fe_queue_ready_o) begin
        n_err++;
        $display("FAIL stream[%0d]: got %s, expected %s", i, fmt(act_o), fmt(exp_o));
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic clr, roll;
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 31) == 0);
      roll = !clr && ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 1), rand_pkt(), 0,
            (n_iss > 0) && ($urandom_range(0, 2) == 0), roll, clr);
      fe_queue_yumi_i = model_out().v && ($urandom_range(0, 1) == 1);
      @(negedge clk_i);
      exp_o = model_out(); act_o = dut_out(); n_cmp++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL random[%0d]: got %s, expected %s", i, fmt(act_o), fmt(exp_o));
      end
      advance();
    end
  endtask

  task automatic test_midreset();
    drive(0, '0, 0, 0, 0, 1);
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(1, rand_pkt(), i == 3, 0, 0, 0);
      advance();
    end
    drive(0, '0, 0, 0, 0, 0);
    @(negedge clk_i);
    #1 reset_n_i = 1'b0;
    q.delete();
    n_iss = 0;
    #1;
    act_o = dut_out(); n_cmp++;
    if (act_o !== obs_t'{1'b0, '0, 1'b1, '0}) begin
      n_err++;
      $display("FAIL midreset_async: got %s, expected v=0 ready=1 count=0", fmt(act_o));
    end
    advance();
    @(negedge clk_i);
    #1 reset_n_i = 1'b1;
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1, rand_pkt(), 0, 0, 0, 0);
      fe_queue_yumi_i = model_out().v;
      @(negedge clk_i);
      exp_o = model_out(); act_o = dut_out(); n_cmp++;
      if (act_o !== exp_o) begin
        n_err++;
        $display("FAIL midreset_after[%0d]: got %s, expected %s", i, fmt(act_o), fmt(exp_o));
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill();
    test_roll();
    test_deq_roll();
    test_clr();
    test_stream();
    test_random();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_fe_queue_ckpt.md
# bp_fe_queue_ckpt

Checkpointing instruction queue between the front end and the back-end scheduler. FE enqueues fetch packets with a valid/ready handshake. The scheduler reads speculatively (yumi), commits entries (deq), rewinds to the last commit point (roll), or discards everything (clr). An entry's slot is freed only when it is committed, so a rolled-back instruction can be reissued without refetch.

## Interface
Parameters:
- width_p, 128, fe_queue packet width in bits
- els_p, 8, entry count; power of two, at least 2
- ptr_width_lp, $clog2(els_p)+1, pointer width including the wrap bit (localparam)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- reset_n_i  in  1  asynchronous active-low reset
- fe_queue_i  in  width_p  enqueue packet from FE
- fe_queue_v_i  in  1  enqueue valid
- fe_queue_ready_o  out  1  space available; an enqueue occurs when v_i & ready_o
- fe_queue_o  out  width_p  packet at the speculative read pointer
- fe_queue_v_o  out  1  speculative read entry present
- fe_queue_yumi_i  in  1  consume current read entry; legal only when v_o=1
- fe_queue_deq_i  in  1  commit the oldest issued entry
- fe_queue_roll_i  in  1  rewind the read pointer to the commit pointer
- fe_queue_clr_i  in  1  discard all entries
- count_o  out  ptr_width_lp  committed occupancy, wptr-cptr

## Operation
- Three pointers, each ptr_width_lp wide and wrapping modulo 2*els_p: wptr (write), rptr (speculative read), cptr (commit). The low bits index the flop array.
- full = (wptr.idx==cptr.idx) & (wptr.wrap!=cptr.wrap); ready_o = ~full.
- v_o = (rptr != wptr). fe_queue_o = mem[rptr.idx] is a combinational read.
- enq: mem[wptr]<=fe_queue_i; wptr+1.
- yumi: rptr+1.
- deq: cptr+1. Legal only when cptr!=rptr, i.e. at least one issued, uncommitted entry.
- Priority for rptr/cptr: clr > roll > yumi/deq.
  - clr: rptr<=wptr_next, cptr<=wptr_next. An enqueue in the same cycle is accepted and discarded.
  - roll: rptr<=cptr_next. A deq in the same cycle is applied first; a yumi in the same cycle is ignored.
  - yumi and deq in the same cycle: both apply independently.
- Illegal cases are checked with assertions that are disabled during reset: yumi without v_o; deq with cptr==rptr; roll together with clr (clr wins).

## Timing
- Reset (async assert, sync release internally not required): all pointers 0, fe_queue_v_o=0, fe_queue_ready_o=1, count_o=0. Memory contents are not reset.
- Enqueue-to-visible latency is 1 cycle: v_o rises the cycle after the accepting edge.
- Full to ready: ready_o rises the cycle after the deq or clr that frees a slot. ready_o has no combinational path from v_i, deq_i, or clr_i.
- Wrap-around: pointers roll from 2*els_p-1 to 0; full/empty remain correct across the wrap.
- Reset asserted mid-operation clears pointers immediately. Outputs return to reset values without waiting for a clock.

## Configuration
- BP_FE_QUEUE_BYPASS_EN defined:
  - When rptr==wptr and neither roll nor clr is asserted, fe_queue_o=fe_queue_i and fe_queue_v_o=fe_queue_v_i&ready_o in the same cycle, giving 0-cycle latency.
  - The entry is still written to the array, so a later roll reissues it.
  - A yumi of the bypassed entry advances rptr together with wptr.
- Undefined: no bypass. Enqueue-to-visible latency is always 1 cycle, and there is no combinational path from fe_queue_*_i to fe_queue_*_o.

## Test plan
- Reset, then enqueue 8 packets (els_p=8) on back-to-back cycles → ready_o=0 after the 8th, count_o=8, v_o=1 throughout.
- yumi 3 packets, assert roll → fe_queue_o returns packet 0 next cycle; count_o stays 8.
- yumi 2, deq 2, roll → fe_queue_o is packet 2; ready_o rises 1 cycle after the deq; count_o=6.
- Enqueue while asserting clr → v_o=0, count_o=0, and the new packet is never presented.
- Stream 20 packets with yumi+deq every cycle → in-order output across the pointer wrap, no drops, ready_o never deasserts.
- Assert reset_n_i low mid-stream, between clock edges → v_o=0, ready_o=1, count_o=0 before the next edge.
- With BP_FE_QUEUE_BYPASS_EN and the queue empty, enqueue packet 0xA5 → v_o=1 and fe_queue_o=0xA5 in the same cycle.
